spart_rx: RTL and testbench
===========================

Name: spart_rx

Overview:
- Serial receive stage of the SPART. Feeds the CPU key-decode stage.
- Oversamples the asynchronous RxD line at 16x and deframes 8N1 characters, LSB first.
- Presents each received byte on databus and asserts rda, the level the downstream stage edge-detects.
- Flags framing errors and overruns, and guarantees a fresh rising edge on rda for every accepted byte.

Parameters:
- DIVISOR, 163: clock cycles per 16x sample tick. Bit period = 16*DIVISOR clocks. Legal range 2..65535.
- DIV_W, 16: width of the tick counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- rxd  in  1  asynchronous serial input, idle high
- rd_ack  in  1  one-cycle pulse from consumer; clears rda, frame_err and overrun
- databus  out  8  last good received byte
- rda  out  1  receive data available (level)
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: new byte accepted while rda still set
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - databus = 8'h00; rda, frame_err, overrun and busy = 0.
  - Both synchronizer flops = 1; state = IDLE; all counters = 0.
- Synchronizer: rxd passes through two flops; rxd_s is the second flop. All logic uses rxd_s only.
- Tick counter:
  - Counts 0..DIVISOR-1 while state != IDLE; tick = 1 when the count equals DIVISOR-1, then wraps to 0.
  - Held at 0 in IDLE.
  - smp (4 bits) counts ticks within a bit.
- IDLE: rxd_s == 0 -> START, with smp = 0 and tick counter = 0.
- START: at the 8th tick (mid start bit), sample rxd_s.
  - 0 -> DATA, with smp = 0 and bit index = 0.
  - 1 -> IDLE (glitch rejected; no flags change).
- DATA: every 16th tick, sample rxd_s into shift[bit index] (LSB first). After bit index 7 -> STOP.
- STOP: at the 16th tick, sample rxd_s.
  - 1 (good stop bit): databus <= shift on the next clk edge.
    - If rda == 0: rda <= 1.
    - If rda == 1 (unacked): overrun <= 1, rda <= 0 for exactly one cycle, then 1. This guarantees a rising edge for the downstream edge detector. databus is overwritten with the new byte.
    - Then -> IDLE.
  - 0 (bad stop bit): frame_err <= 1; databus and rda are unchanged. -> BREAK.
- BREAK: wait until rxd_s == 1, then -> IDLE. A held-low line therefore produces exactly one frame_err, not repeated frames.
- Latency:
  - rda rises 1 clk after the stop-bit sample tick.
  - End-to-end from the rxd start edge: 2 (sync) + (8 + 16*9)*DIVISOR + 1 clocks, ±1 clk of synchronizer uncertainty.
- rd_ack: clears rda, frame_err and overrun on the next edge.
  - rd_ack in the same cycle as a byte-accept: the accept wins (rda = 1, flags updated per accept). rd_ack is ignored that cycle.
  - rd_ack in the cycle of the forced-low overrun pulse: rda still returns to 1 next cycle; overrun is cleared.
- Reset mid-frame: immediate return to IDLE with reset values; the partial byte is discarded.
- A start bit arriving during the overrun low-pulse cycle is handled normally; the receive path is independent of rda.

Decomposition:
- Shared spart package holds:
  - state encoding (IDLE, START, DATA, STOP, BREAK, 3-bit)
  - OVERSAMPLE = 16 and MID_SAMPLE = 8
  - the 8N1 frame constants
- One natural sub-module: spart_baud_tick (DIVISOR counter with clear/enable, emits tick). It is reused by the future spart_tx.

Test Plan (DIVISOR = 4, bit period = 64 clk):
- Reset and idle: hold rst low, rxd = 1, 200 clk -> databus = 8'h00, rda = 0, busy = 0 throughout. Release rst -> no change.
- Single byte 8'h77 ('w'), 8N1 -> rda rises at (start edge + 2 + 8*4 + 144*4 + 1) ±1 clk, databus = 8'h77, frame_err = 0. Pulse rd_ack -> rda = 0 next cycle.
- Overrun: send 8'h61 then 8'h73 with no rd_ack -> after the 2nd stop bit, rda = 0 for exactly 1 cycle then 1, databus = 8'h73, overrun = 1. rd_ack -> overrun = 0, rda = 0.
- Framing error: send 8'h64 with stop bit 0, line held low 300 clk, then high -> frame_err = 1 exactly once, rda stays 0, databus unchanged, busy = 1 until rxd high then 0. Next good byte 8'h20 -> rda = 1, databus = 8'h20.
- Glitch and reset: 20-clk low pulse on rxd -> returns to IDLE, no flags. Separately, rst low mid-DATA for 1 clk -> all outputs at reset values, and the following byte 8'h6C is received correctly.
- rd_ack coincident with the accept cycle of 8'h6A -> rda = 1 and databus = 8'h6A afterwards (accept wins).

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: FSM state encoding, oversampling and 8N1 frame constants.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } spart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  // 8N1 framing: start bit low, 8 data bits LSB first, no parity, one stop bit high.
  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Oversample tick index at which each sample point falls.
  localparam logic [3:0] SMP_MID  = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

endpackage

// File: rtl/spart_baud_tick.sv
// Divide-by-DIVISOR tick generator; one-cycle tick each time the count reaches DIVISOR-1.
module spart_baud_tick #(
  parameter int DIVISOR = 163,
  parameter int DIV_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIVISOR - 1);

  logic [DIV_W-1:0] cnt;

  // Count while enabled, wrap after DIVISOR-1, hold at zero when cleared or disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 deframer with framing-error and overrun flags.
module spart_rx
  import spart_pkg::*;
#(
  parameter int DIVISOR = 163,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_ack,
  output logic [7:0] databus,
  output logic       rda,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  spart_state_t state, nstate;

  logic       rxd_p0;
  logic       rxd_p1;
  logic       rxd_s;
  logic       tick;
  logic       start_det;
  logic       accept;
  logic       bad_stop;
  logic       data_smp;
  logic       rda_pend;
  logic [3:0] smp;
  logic [2:0] bit_idx;
  logic [7:0] shift;

  // Two-flop synchronizer; idle-high reset value keeps the FSM out of START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  assign rxd_s     = rxd_p1;
  assign busy      = (state != IDLE);
  assign start_det = (state == IDLE) && (rxd_s == START_LEVEL);
  assign data_smp  = (state == DATA) && tick && (smp == SMP_LAST);

  spart_baud_tick #(
    .DIVISOR (DIVISOR),
    .DIV_W   (DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_det),
    .en   (busy),
    .tick (tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state logic plus one-cycle accept / bad-stop strobes at the stop sample.
  always_comb begin
    nstate   = state;
    accept   = 1'b0;
    bad_stop = 1'b0;
    case (state)
      IDLE: begin
        if (rxd_s == START_LEVEL) nstate = START;
      end
      START: begin
        if (tick && (smp == SMP_MID)) begin
          nstate = (rxd_s == START_LEVEL) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (data_smp && (bit_idx == BIT_LAST)) nstate = STOP;
      end
      STOP: begin
        if (tick && (smp == SMP_LAST)) begin
          if (rxd_s == STOP_LEVEL) begin
            accept = 1'b1;
            nstate = IDLE;
          end else begin
            bad_stop = 1'b1;
            nstate   = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxd_s == STOP_LEVEL) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Oversample and bit counters; smp restarts at mid start bit so data samples land mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp     <= '0;
      bit_idx <= '0;
    end else begin
      if (state == IDLE) begin
        smp <= '0;
      end else if (tick) begin
        if ((state == START) && (smp == SMP_MID)) smp <= '0;
        else                                      smp <= smp + 4'd1;
      end
      if (state == START)  bit_idx <= '0;
      else if (data_smp)   bit_idx <= bit_idx + 3'd1;
    end
  end

  // Data shift register, LSB first; contents only matter once a full frame is in.
  always_ff @(posedge clk) begin
    if (data_smp) shift[bit_idx] <= rxd_s;
  end

  // Consumer-facing outputs; an unacked accept forces rda low for one cycle so the
  // downstream edge detector always sees a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      databus   <= 8'h00;
      rda       <= 1'b0;
      rda_pend  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (accept) begin
      databus <= shift;
      if (rda) begin
        rda      <= 1'b0;
        rda_pend <= 1'b1;
        overrun  <= 1'b1;
      end else begin
        rda      <= 1'b1;
        rda_pend <= 1'b0;
      end
    end else begin
      if (rda_pend) begin
        rda      <= 1'b1;
        rda_pend <= 1'b0;
      end else if (rd_ack) begin
        rda <= 1'b0;
      end
      if (rd_ack) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (bad_stop) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Directed testbench for spart_rx with DIVISOR = 4 (64 clocks per bit).
module tb_spart_rx;

  localparam int DIVISOR = 4;
  localparam int BITCLK  = 16 * DIVISOR;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] databus;
  logic       rda;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int passed = 0;
  int total  = 0;

  int cyc       = 0;
  int start_cyc = 0;
  int last_rise = 0;
  int last_fall = 0;
  int rise_cnt  = 0;
  int fe_cnt    = 0;
  logic prev_rda = 1'b0;
  logic prev_fe  = 1'b0;

  spart_rx #(.DIVISOR(DIVISOR), .DIV_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rd_ack    (rd_ack),
    .databus   (databus),
    .rda       (rda),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge history of rda and frame_err, read back by the directed steps.
  always @(negedge clk) begin
    prev_rda <= rda;
    prev_fe  <= frame_err;
    if (rda && !prev_rda) begin
      last_rise <= cyc;
      rise_cnt  <= rise_cnt + 1;
    end
    if (!rda && prev_rda) last_fall <= cyc;
    if (frame_err && !prev_fe) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 rd_ack = 1'b1;
    @(posedge clk); #1 rd_ack = 1'b0;
  endtask

  // Drive one full 8N1 frame; rd_ack is raised for the single cycle at offset ack_off.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int ack_off);
    logic bv;
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < BITCLK; i++) begin
        @(posedge clk);
        #1;
        if (b == 0 && i == 0) start_cyc = cyc;
        if (b == 0)      bv = 1'b0;
        else if (b == 9) bv = stopb;
        else             bv = d[b-1];
        rxd    = bv;
        rd_ack = (ack_off >= 0) && ((cyc - start_cyc) == ack_off);
      end
    end
    rd_ack = 1'b0;
  endtask

  int lat;
  int r0;
  int f0;

  initial begin
    rst    = 1'b0;
    rxd    = 1'b1;
    rd_ack = 1'b0;

    // Reset and idle
    for (int k = 0; k < 4; k++) begin
      clks(50);
      at_neg();
      chk("rst_databus", 32'(databus), 32'h00);
      chk("rst_rda", 32'(rda), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    chk("rst_flags", 32'({frame_err, overrun}), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    clks(10);
    at_neg();
    chk("rel_databus", 32'(databus), 32'h00);
    chk("rel_rda", 32'(rda), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);

    // Single byte 8'h77
    send_frame(8'h77, 1'b1, -1);
    at_neg();
    lat = last_rise - start_cyc;
    chk("lat_77", 32'((lat >= 610) && (lat <= 612)), 32'h1);
    chk("rda_77", 32'(rda), 32'h1);
    chk("data_77", 32'(databus), 32'h77);
    chk("fe_77", 32'(frame_err), 32'h0);
    chk("ovr_77", 32'(overrun), 32'h0);
    chk("busy_after_77", 32'(busy), 32'h0);
    chk("rises_77", 32'(rise_cnt), 32'd1);
    pulse_ack();
    at_neg();
    chk("ack_77", 32'(rda), 32'h0);

    // Overrun: 8'h61 then 8'h73 without acknowledgement
    send_frame(8'h61, 1'b1, -1);
    at_neg();
    chk("rda_61", 32'(rda), 32'h1);
    chk("data_61", 32'(databus), 32'h61);
    send_frame(8'h73, 1'b1, -1);
    at_neg();
    chk("ovr_pulse_len", 32'(last_rise - last_fall), 32'd1);
    chk("ovr_fall_time", 32'((last_fall - start_cyc) == lat), 32'h1);
    chk("ovr_rda", 32'(rda), 32'h1);
    chk("ovr_data", 32'(databus), 32'h73);
    chk("ovr_flag", 32'(overrun), 32'h1);
    pulse_ack();
    at_neg();
    chk("ovr_clr", 32'(overrun), 32'h0);
    chk("ovr_ack_rda", 32'(rda), 32'h0);

    // Framing error: 8'h64 with low stop bit, line held low
    r0 = rise_cnt;
    f0 = fe_cnt;
    send_frame(8'h64, 1'b0, -1);
    clks(300);
    at_neg();
    chk("brk_busy", 32'(busy), 32'h1);
    chk("brk_fe", 32'(frame_err), 32'h1);
    rxd = 1'b1;
    clks(5);
    at_neg();
    chk("brk_idle", 32'(busy), 32'h0);
    chk("fe_once", 32'(fe_cnt - f0), 32'd1);
    chk("fe_rda", 32'(rda), 32'h0);
    chk("fe_rises", 32'(rise_cnt - r0), 32'd0);
    chk("fe_data", 32'(databus), 32'h73);
    pulse_ack();
    at_neg();
    chk("fe_clr", 32'(frame_err), 32'h0);
    send_frame(8'h20, 1'b1, -1);
    at_neg();
    chk("rda_20", 32'(rda), 32'h1);
    chk("data_20", 32'(databus), 32'h20);

    // Glitch: 20-clock low pulse is rejected at mid start bit
    r0 = rise_cnt;
    f0 = fe_cnt;
    @(posedge clk); #1 rxd = 1'b0;
    clks(10);
    at_neg();
    chk("glitch_busy", 32'(busy), 32'h1);
    clks(10);
    rxd = 1'b1;
    clks(60);
    at_neg();
    chk("glitch_idle", 32'(busy), 32'h0);
    chk("glitch_flags", 32'({frame_err, overrun}), 32'h0);
    chk("glitch_rises", 32'(rise_cnt - r0), 32'd0);
    chk("glitch_fe", 32'(fe_cnt - f0), 32'd0);
    chk("glitch_data", 32'(databus), 32'h20);

    // Reset during DATA
    @(posedge clk); #1 rxd = 1'b0;
    clks(BITCLK);
    rxd = 1'b1;
    clks(BITCLK);
    rxd = 1'b0;
    clks(BITCLK / 2);
    at_neg();
    chk("mid_busy", 32'(busy), 32'h1);
    rxd = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #2;
    chk("mrst_data", 32'(databus), 32'h00);
    chk("mrst_rda", 32'(rda), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    clks(20);
    at_neg();
    chk("mrst_idle", 32'(busy), 32'h0);
    send_frame(8'h6C, 1'b1, -1);
    at_neg();
    chk("rda_6c", 32'(rda), 32'h1);
    chk("data_6c", 32'(databus), 32'h6C);
    chk("ovr_6c", 32'(overrun), 32'h0);
    pulse_ack();
    at_neg();
    chk("ack_6c", 32'(rda), 32'h0);

    // rd_ack coincident with the accept cycle of 8'h6A
    send_frame(8'h6A, 1'b1, lat - 1);
    at_neg();
    chk("coin_rise", 32'(last_rise - start_cyc), 32'(lat));
    chk("coin_rda", 32'(rda), 32'h1);
    chk("coin_data", 32'(databus), 32'h6A);
    chk("coin_ovr", 32'(overrun), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
